seg7_scan_encoder: RTL and testbench



---
 rtl/seg7_scan_encoder.sv | 177 +++++++++++++++++
 tb/tb_seg7_scan_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder
// Sniffs an anode-scanned seven-segment bus and recovers the digit codes.
// A digit is accepted once its (segment, anode) sample has been stable for
// STABLE_CYCLES registered samples; a complete frame is offered on a
// valid/ready output.
//
// Optional feature macro: SEG7_SCAN_HEX_EN (also decode A..F glyphs).
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   seg_i        segment bus, seg_i[6]=a .. seg_i[0]=g, active-high
//   an_i         anode strobes, active-high, one-hot while a digit is driven
//   out_ready    consumer accepts the presented frame
//   clr_ovf_i    synchronous clear of overflow_o
//   out_valid    frame available on digits_o / err_o
//   digits_o     digit i code at [4i+3:4i]
//   err_o        per-digit unrecognised-pattern flag
//   overflow_o   sticky: a completed frame was dropped
module seg7_scan_encoder #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg_i,
   input  logic [DIGITS-1:0]     an_i,
   input  logic                  out_ready,
   input  logic                  clr_ovf_i,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   digits_o,
   output logic [DIGITS-1:0]     err_o,
   output logic                  overflow_o
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

   // Returns {err, code}.
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = 5'h00;
         7'h30:   r = 5'h01;
         7'h6D:   r = 5'h02;
         7'h79:   r = 5'h03;
         7'h33:   r = 5'h04;
         7'h5B:   r = 5'h05;
         7'h5F:   r = 5'h06;
         7'h70:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h7B:   r = 5'h09;
`ifdef SEG7_SCAN_HEX_EN
         7'h77:   r = 5'h0A;
         7'h1F:   r = 5'h0B;
         7'h4E:   r = 5'h0C;
         7'h3D:   r = 5'h0D;
         7'h4F:   r = 5'h0E;
         7'h47:   r = 5'h0F;
`endif
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   state_t                state_q, state_d;
   logic [6:0]            s_seg_q, s_seg_d;
   logic [DIGITS-1:0]     s_an_q, s_an_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DIGITS-1:0]     seen_q, seen_d;
   logic [4*DIGITS-1:0]   slot_code_q, slot_code_d;
   logic [DIGITS-1:0]     slot_err_q, slot_err_d;
   logic                  out_valid_q, out_valid_d;
   logic [4*DIGITS-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]     err_q, err_d;
   logic                  ovf_q, ovf_d;

   logic                  changed;
   logic                  capture;
   logic [4:0]            dec;
   logic [DIGITS-1:0]     seen_next;

   always_comb begin
      state_d     = state_q;
      s_seg_d     = seg_i;
      s_an_d      = an_i;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      slot_code_d = slot_code_q;
      slot_err_d  = slot_err_q;
      out_valid_d = out_valid_q;
      digits_d    = digits_q;
      err_d       = err_q;
      ovf_d       = ovf_q;
      capture     = 1'b0;
      dec         = decode(s_seg_q);
      seen_next   = seen_q;

      // The incoming sample is compared with the one already held, so the
      // edge that registers a new sample is also the edge where cnt becomes 1.
      changed = (seg_i != s_seg_q) || (an_i != s_an_q);

      if (changed) begin
         cnt_d   = CW'(1);
         state_d = $onehot(an_i) ? SETTLE : IDLE;
      end else if (state_q == SETTLE) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q + CW'(1) == CW'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = CAPTURED;
         end
      end

      if (out_valid_q && out_ready)
         out_valid_d = 1'b0;

      if (clr_ovf_i)
         ovf_d = 1'b0;

      if (capture) begin
         // Unchanged sample in SETTLE implies s_an_q is one-hot.
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (s_an_q[i]) begin
               slot_code_d[4*i +: 4] = dec[3:0];
               slot_err_d[i]         = dec[4];
               seen_next[i]          = 1'b1;
            end
         end
         if (&seen_next) begin
            seen_d = '0;
            if (!out_valid_q || out_ready) begin
               digits_d    = slot_code_d;
               err_d       = slot_err_d;
               out_valid_d = 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            seen_d = seen_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_seg_q     <= '0;
         s_an_q      <= '0;
         cnt_q       <= '0;
         seen_q      <= '0;
         slot_code_q <= '0;
         slot_err_q  <= '0;
         out_valid_q <= 1'b0;
         digits_q    <= '0;
         err_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_seg_q     <= s_seg_d;
         s_an_q      <= s_an_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         slot_code_q <= slot_code_d;
         slot_err_q  <= slot_err_d;
         out_valid_q <= out_valid_d;
         digits_q    <= digits_d;
         err_q       <= err_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign digits_o   = digits_q;
   assign err_o      = err_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// Bench for seg7_scan_encoder (DIGITS=4, STABLE_CYCLES=4).
// The reference model tracks how long the bus has held the same value and
// accepts a digit when that run reaches STABLE_CYCLES on a one-hot anode.
module tb_seg7_scan_encoder;
   localparam int unsigned D = 4;
   localparam int unsigned S = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    seg_i;
   logic [D-1:0]  an_i;
   logic          out_ready;
   logic          clr_ovf_i;
   logic          out_valid;
   logic [4*D-1:0] digits_o;
   logic [D-1:0]  err_o;
   logic          overflow_o;

   seg7_scan_encoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n), .seg_i(seg_i), .an_i(an_i),
      .out_ready(out_ready), .clr_ovf_i(clr_ovf_i), .out_valid(out_valid),
      .digits_o(digits_o), .err_o(err_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Glyph table, index = digit value.
   localparam logic [6:0] TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
      7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG7_SCAN_HEX_EN
   localparam int NGLYPH = 16;
`else
   localparam int NGLYPH = 10;
`endif

   function automatic logic [4:0] mdec(input logic [6:0] p);
      for (int k = 0; k < NGLYPH; k++)
         if (p == TBL[k]) return {1'b0, 4'(k)};
      return 5'h1F;
   endfunction

   // ---------------- model state ----------------
   logic [6:0]    m_prev_seg;
   logic [D-1:0]  m_prev_an;
   int            m_run;
   logic [3:0]    m_code [D];
   logic          m_cerr [D];
   logic [D-1:0]  m_seen;
   logic          m_valid;
   logic [4*D-1:0] m_digits;
   logic [D-1:0]  m_err;
   logic          m_ovf;

   int            vcycles = 0;
   logic [4*D-1:0] last_frame;
   logic [D-1:0]  last_err;

   task automatic model_reset();
      m_prev_seg = '0; m_prev_an = '0; m_run = 0; m_seen = '0;
      m_valid = 1'b0; m_digits = '0; m_err = '0; m_ovf = 1'b0;
      for (int i = 0; i < D; i++) begin m_code[i] = '0; m_cerr[i] = 1'b0; end
   endtask

   task automatic model_step();
      logic       free;
      logic [4:0] r;
      int         idx;
      if (seg_i == m_prev_seg && an_i == m_prev_an) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run = 1;
      end
      m_prev_seg = seg_i;
      m_prev_an  = an_i;
      free = !m_valid || out_ready;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (clr_ovf_i) m_ovf = 1'b0;
      if (m_run == S && $countones(an_i) == 1) begin
         idx = 0;
         for (int i = 0; i < D; i++) if (an_i[i]) idx = i;
         r = mdec(seg_i);
         m_code[idx] = r[3:0];
         m_cerr[idx] = r[4];
         m_seen[idx] = 1'b1;
         if (&m_seen) begin
            m_seen = '0;
            if (free) begin
               for (int i = 0; i < D; i++) begin
                  m_digits[4*i +: 4] = m_code[i];
                  m_err[i] = m_cerr[i];
               end
               m_valid = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   endtask

   // Model update and per-cycle compare (also fires on async reset assertion).
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
         #1;
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("digits_o", 32'(digits_o), 32'(m_digits));
         check("err_o", 32'(err_o), 32'(m_err));
         check("overflow_o", 32'(overflow_o), 32'(m_ovf));
         if (out_valid) begin
            vcycles++;
            last_frame = digits_o;
            last_err = err_o;
         end
      end
   end

   task automatic hold(input logic [6:0] s, input logic [D-1:0] a, input int n);
      seg_i = s;
      an_i  = a;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input int c0, input int c1, input int c2, input int c3);
      hold(TBL[c0], 4'b0001, 6);
      hold(TBL[c1], 4'b0010, 6);
      hold(TBL[c2], 4'b0100, 6);
      hold(TBL[c3], 4'b1000, 6);
   endtask

   int v0;

   initial begin
      rst_n = 1'b0; seg_i = '0; an_i = '0; out_ready = 1'b1; clr_ovf_i = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_digits", 32'(digits_o), 32'd0);
      check("reset_ovf", 32'(overflow_o), 32'd0);
      rst_n = 1'b1;
      hold(7'h00, 4'b0000, 2);

      // Basic scan 0,1,2,3
      v0 = vcycles;
      scan(0, 1, 2, 3);
      hold(7'h00, 4'b0000, 3);
      check("t1_pulses", 32'(vcycles - v0), 32'd1);
      check("t1_frame", 32'(last_frame), 32'h3210);
      check("t1_err", 32'(last_err), 32'h0);

      // Digit 1 glitched for 3 cycles, then recaptured
      v0 = vcycles;
      hold(TBL[5], 4'b0001, 6);
      hold(TBL[6], 4'b0010, 3);
      hold(TBL[7], 4'b0100, 6);
      hold(TBL[8], 4'b1000, 6);
      check("t2_no_frame", 32'(vcycles - v0), 32'd0);
      hold(TBL[9], 4'b0010, 6);
      hold(7'h00, 4'b0000, 3);
      check("t2_pulses", 32'(vcycles - v0), 32'd1);
      check("t2_frame", 32'(last_frame), 32'h8795);

      // 0x77 on digit 2
      scan(0, 1, 10, 3);
      hold(7'h00, 4'b0000, 3);
`ifdef SEG7_SCAN_HEX_EN
      check("t3_frame", 32'(last_frame), 32'h3A10);
      check("t3_err", 32'(last_err), 32'h0);
`else
      check("t3_frame", 32'(last_frame), 32'h3F10);
      check("t3_err", 32'(last_err), 32'h4);
`endif

      // Back-pressure: second frame dropped
      out_ready = 1'b0;
      scan(1, 2, 3, 4);
      scan(9, 9, 9, 9);
      hold(7'h00, 4'b0000, 2);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_frame_held", 32'(digits_o), 32'h4321);
      check("t4_ovf", 32'(overflow_o), 32'd1);
      clr_ovf_i = 1'b1;
      @(negedge clk);
      clr_ovf_i = 1'b0;
      check("t4_ovf_clr", 32'(overflow_o), 32'd0);
      check("t4_valid_still", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("t4_valid_drop", 32'(out_valid), 32'd0);

      // Multi-hot and zero anodes never capture
      v0 = vcycles;
      hold(TBL[0], 4'b0001, 6);
      hold(TBL[1], 4'b0010, 6);
      hold(TBL[2], 4'b0100, 6);
      hold(TBL[0], 4'b0011, 20);
      hold(TBL[0], 4'b0000, 10);
      check("t5_no_frame", 32'(vcycles - v0), 32'd0);
      hold(TBL[3], 4'b1000, 6);
      hold(7'h00, 4'b0000, 3);
      check("t5_pulses", 32'(vcycles - v0), 32'd1);
      check("t5_frame", 32'(last_frame), 32'h3210);

      // Async reset mid-SETTLE with a frame pending
      out_ready = 1'b0;
      scan(5, 6, 7, 8);
      check("t6_valid", 32'(out_valid), 32'd1);
      hold(TBL[0], 4'b0001, 2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_digits", 32'(digits_o), 32'd0);
      check("t6_rst_err", 32'(err_o), 32'd0);
      check("t6_rst_ovf", 32'(overflow_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      v0 = vcycles;
      scan(0, 1, 2, 3);
      hold(7'h00, 4'b0000, 3);
      check("t6_pulses", 32'(vcycles - v0), 32'd1);
      check("t6_frame", 32'(last_frame), 32'h3210);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
